// File: rtl/keccak_step_sequencer.sv
// Step sequencer for one Keccak pass: column parity per slice, rotate per lane, then permutation.
// Optional handshake watchdog enabled by defining STEP_TIMEOUT_EN.
module keccak_step_sequencer #(
  parameter int unsigned SLICES  = 64,
  parameter int unsigned LANES   = 25,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       colparDone,
  input  logic       finishLane,
  input  logic       perm_done,
  output logic       busy,
  output logic       done,
  output logic       colparIJrster,
  output logic       ld_ij_par,
  output logic [5:0] slice_idx,
  output logic       initRotate,
  output logic       en_rotate,
  output logic [4:0] laneid,
  output logic       perm_start,
  output logic [3:0] state_o,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CP_INIT    = 4'd1,
    S_CP_RUN     = 4'd2,
    S_ROT_INIT   = 4'd3,
    S_ROT_RUN    = 4'd4,
    S_PERM_START = 4'd5,
    S_PERM_WAIT  = 4'd6,
    S_DONE       = 4'd7,
    S_ERR        = 4'd8
  } state_t;

  localparam logic [5:0] SLICE_LAST = 6'(SLICES - 1);
  localparam logic [4:0] LANE_LAST  = 5'(LANES - 1);

  // Index widths are fixed by the port list; reject configurations that cannot fit.
  if (SLICES < 1 || SLICES > 64 || LANES < 1 || LANES > 32 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("keccak_step_sequencer: parameter out of range");
  end

  state_t     state, state_n;
  logic [5:0] slice_n;
  logic [4:0] lane_n;

`ifdef STEP_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wcnt, wcnt_n;
  logic       err_q, err_n;
  logic       in_wait, acked;
`endif

  always_comb begin
    state_n = state;
    slice_n = slice_idx;
    lane_n  = laneid;
`ifdef STEP_TIMEOUT_EN
    wcnt_n  = wcnt;
    err_n   = err_q;
    in_wait = 1'b0;
    acked   = 1'b0;
`endif
    unique case (state)
      S_IDLE:
        if (start) begin
          state_n = S_CP_INIT;
          slice_n = '0;
          lane_n  = '0;
        end
      S_CP_INIT:    state_n = S_CP_RUN;
      S_CP_RUN:
        if (colparDone) begin
          if (slice_idx == SLICE_LAST) state_n = S_ROT_INIT;
          else begin
            slice_n = slice_idx + 6'd1;
            state_n = S_CP_INIT;
          end
        end
      S_ROT_INIT:   state_n = S_ROT_RUN;
      S_ROT_RUN:
        if (finishLane) begin
          if (laneid == LANE_LAST) state_n = S_PERM_START;
          else begin
            lane_n  = laneid + 5'd1;
            state_n = S_ROT_INIT;
          end
        end
      S_PERM_START: state_n = S_PERM_WAIT;
      S_PERM_WAIT:  if (perm_done) state_n = S_DONE;
      S_DONE:       state_n = S_IDLE;
      default:      state_n = state;
    endcase

`ifdef STEP_TIMEOUT_EN
    // Watchdog overlays the case above: only the three ack-wait states count.
    in_wait = (state == S_CP_RUN) || (state == S_ROT_RUN) || (state == S_PERM_WAIT);
    acked   = ((state == S_CP_RUN) && colparDone) || ((state == S_ROT_RUN) && finishLane) ||
              ((state == S_PERM_WAIT) && perm_done);
    if (in_wait && !acked) begin
      if (wcnt == WAIT_LAST) state_n = S_ERR;
      else wcnt_n = wcnt + 8'd1;
    end
    if (state_n != state &&
        (state_n == S_CP_RUN || state_n == S_ROT_RUN || state_n == S_PERM_WAIT))
      wcnt_n = '0;
`endif

    if (abort) begin
      state_n = S_IDLE;
      slice_n = '0;
      lane_n  = '0;
    end

`ifdef STEP_TIMEOUT_EN
    if (state_n == S_ERR) err_n = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      slice_idx <= '0;
      laneid    <= '0;
`ifdef STEP_TIMEOUT_EN
      wcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      slice_idx <= slice_n;
      laneid    <= lane_n;
`ifdef STEP_TIMEOUT_EN
      wcnt      <= wcnt_n;
      err_q     <= err_n;
`endif
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign colparIJrster = (state == S_CP_INIT);
  assign ld_ij_par     = (state == S_CP_RUN);
  assign initRotate    = (state == S_ROT_INIT);
  assign en_rotate     = (state == S_ROT_RUN);
  assign perm_start    = (state == S_PERM_START);
  assign state_o       = state;

`ifdef STEP_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_step_sequencer.sv
// Scoreboard bench for keccak_step_sequencer: expected pulse/index events are queued
// before each pass and matched against events observed on the outputs.
module tb_keccak_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       colparDone = 1'b0, finishLane = 1'b0, perm_done = 1'b0;
  logic       busy, done, colparIJrster, ld_ij_par, initRotate, en_rotate, perm_start, err;
  logic [5:0] slice_idx;
  logic [4:0] laneid;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  kind;   // 1 cp init, 5 cp run, 2 rot init, 3 perm start, 4 done
    logic [15:0] idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  keccak_step_sequencer #(.SLICES(64), .LANES(25), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .colparDone(colparDone), .finishLane(finishLane), .perm_done(perm_done),
    .busy(busy), .done(done), .colparIJrster(colparIJrster), .ld_ij_par(ld_ij_par),
    .slice_idx(slice_idx), .initRotate(initRotate), .en_rotate(en_rotate),
    .laneid(laneid), .perm_start(perm_start), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  task automatic push_expect(input int nslices, input int nlanes, input bit perm, input bit fin);
    for (int s = 0; s < nslices; s++) begin
      exp_q.push_back('{kind: 4'd1, idx: 16'(s)});
      exp_q.push_back('{kind: 4'd5, idx: 16'(s)});
    end
    for (int l = 0; l < nlanes; l++) exp_q.push_back('{kind: 4'd2, idx: 16'(l)});
    if (perm) exp_q.push_back('{kind: 4'd3, idx: 16'd0});
    if (fin)  exp_q.push_back('{kind: 4'd4, idx: 16'(63 * 32 + 24)});
  endtask

  // Pairs queued expectations with observed events; a missing entry shows as kind 15.
  task automatic sb_drain(output int nbad, output ev_t fe, output ev_t fo);
    ev_t e, o;
    nbad = 0; fe = '0; fo = '0;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      if (e !== o) begin
        if (nbad == 0) begin fe = e; fo = o; end
        nbad++;
      end
    end
  endtask

  task automatic zero_inputs();
    start = 0; abort = 0; colparDone = 0; finishLane = 0; perm_done = 0;
  endtask

  // Drives one pass, answers each handshake on the 2nd cycle of its wait state, records events.
  task automatic drive_pass(input bit hold_cp, input int restart_slice, input int abort_lane,
                            input bit rst_perm, input bit withhold_rot, input int budget,
                            output int ndone, output int rot_cycles, output bit expired);
    int cp_age, rot_age, perm_age;
    bit prev_ld, restarted;
    ndone = 0; rot_cycles = 0; expired = 1;
    cp_age = 0; rot_age = 0; perm_age = 0; prev_ld = 0; restarted = 0;
    @(negedge clk); start = 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 0;
      if (colparIJrster) obs_q.push_back('{kind: 4'd1, idx: 16'(slice_idx)});
      if (ld_ij_par && !prev_ld) obs_q.push_back('{kind: 4'd5, idx: 16'(slice_idx)});
      prev_ld = ld_ij_par;
      if (initRotate) obs_q.push_back('{kind: 4'd2, idx: 16'(laneid)});
      if (perm_start) obs_q.push_back('{kind: 4'd3, idx: 16'd0});
      if (done) begin
        obs_q.push_back('{kind: 4'd4, idx: 16'(slice_idx * 32 + laneid)});
        ndone++;
        zero_inputs(); expired = 0; return;
      end
      if (state_o == 4'd8) begin zero_inputs(); expired = 0; return; end
      if (rst_perm && state_o == 4'd6) begin zero_inputs(); expired = 0; return; end
      cp_age   = ld_ij_par ? cp_age + 1 : 0;
      rot_age  = en_rotate ? rot_age + 1 : 0;
      perm_age = (state_o == 4'd6) ? perm_age + 1 : 0;
      if (rot_age > rot_cycles) rot_cycles = rot_age;
      if (abort_lane >= 0 && en_rotate && laneid == 5'(abort_lane)) begin
        zero_inputs(); abort = 1;
        @(negedge clk);
        abort = 0; expired = 0; return;
      end
      colparDone = hold_cp ? 1'b1 : (cp_age == 2);
      finishLane = !withhold_rot && (rot_age == 2);
      perm_done  = (perm_age == 2);
      if (restart_slice >= 0 && !restarted && colparIJrster && slice_idx == 6'(restart_slice)) begin
        start = 1; restarted = 1;
      end
    end
    zero_inputs();
  endtask

  task automatic test_reset();
    zero_inputs(); rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, colparIJrster, ld_ij_par, initRotate, en_rotate, perm_start, err} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b, required 00000000",
                         {busy, done, colparIJrster, ld_ij_par, initRotate, en_rotate, perm_start, err});
    end
    checks++;
    if ({slice_idx, laneid, state_o} !== 15'd0) begin
      errors++; $display("FAIL reset_regs: slice %0d lane %0d state %0d, required 0 0 0", slice_idx, laneid, state_o);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_full_pass(input string name, input bit hold_cp, input int restart_slice);
    int nd, rc, nbad; bit ex; ev_t fe, fo;
    push_expect(64, 25, 1, 1);
    drive_pass(hold_cp, restart_slice, -1, 0, 0, 2000, nd, rc, ex);
    checks++;
    if (ex !== 1'b0) begin errors++; $display("FAIL %s_timeout: pass did not finish, required done within budget", name); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL %s_done_count: got %0d, required 1", name, nd); end
    sb_drain(nbad, fe, fo);
    checks++;
    if (nbad != 0) begin
      errors++; $display("FAIL %s_events: %0d mismatches, first got kind %0d idx %0d, required kind %0d idx %0d",
                         name, nbad, fo.kind, fo.idx, fe.kind, fe.idx);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, state_o, slice_idx, laneid, err} !== {1'b0, 1'b0, 4'd0, 6'd63, 5'd24, 1'b0}) begin
      errors++; $display("FAIL %s_after_done: busy %b done %b state %0d slice %0d lane %0d err %b, required 0 0 0 63 24 0",
                         name, busy, done, state_o, slice_idx, laneid, err);
    end
  endtask

  task automatic test_abort();
    int nd, rc, nbad; bit ex, saw_done; ev_t fe, fo;
    push_expect(64, 8, 0, 0);
    drive_pass(0, -1, 7, 0, 0, 2000, nd, rc, ex);
    checks++;
    if (ex !== 1'b0) begin errors++; $display("FAIL abort_reach: laneid 7 never reached, required reach"); end
    checks++;
    if ({busy, state_o, laneid, slice_idx} !== 16'd0) begin
      errors++; $display("FAIL abort_idle: busy %b state %0d lane %0d slice %0d, required 0 0 0 0",
                         busy, state_o, laneid, slice_idx);
    end
    saw_done = (nd != 0);
    repeat (5) begin @(negedge clk); saw_done |= done; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulse, required none"); end
    sb_drain(nbad, fe, fo);
    checks++;
    if (nbad != 0) begin
      errors++; $display("FAIL abort_events: %0d mismatches, first got kind %0d idx %0d, required kind %0d idx %0d",
                         nbad, fo.kind, fo.idx, fe.kind, fe.idx);
    end
  endtask

  task automatic test_rst_mid_pass();
    int nd, rc, nbad; bit ex; ev_t fe, fo;
    push_expect(64, 25, 1, 0);
    drive_pass(0, -1, -1, 1, 0, 2000, nd, rc, ex);
    checks++;
    if (state_o !== 4'd6) begin errors++; $display("FAIL rst_mid_reach: state %0d, required 6", state_o); end
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, done, colparIJrster, ld_ij_par, initRotate, en_rotate, perm_start, err,
         slice_idx, laneid, state_o} !== 23'd0) begin
      errors++; $display("FAIL rst_mid_async: busy %b state %0d slice %0d lane %0d, required all 0",
                         busy, state_o, slice_idx, laneid);
    end
    sb_drain(nbad, fe, fo);
    checks++;
    if (nbad != 0 || nd != 0) begin
      errors++; $display("FAIL rst_mid_events: %0d mismatches, %0d done, first got kind %0d idx %0d, required kind %0d idx %0d",
                         nbad, nd, fo.kind, fo.idx, fe.kind, fe.idx);
    end
    @(negedge clk); rst = 0;
    test_full_pass("post_rst_pass", 0, -1);
  endtask

  task automatic test_withheld_lane();
    int nd, rc, nbad; bit ex; ev_t fe, fo;
    push_expect(64, 1, 0, 0);
`ifdef STEP_TIMEOUT_EN
    drive_pass(0, -1, -1, 0, 1, 2000, nd, rc, ex);
    checks++;
    if (ex !== 1'b0) begin errors++; $display("FAIL timeout_reach: ERR state never reached, required 8"); end
    checks++;
    if (rc != 20) begin errors++; $display("FAIL timeout_cycles: waited %0d cycles, required 20", rc); end
    checks++;
    if ({err, busy, state_o} !== {1'b1, 1'b1, 4'd8}) begin
      errors++; $display("FAIL timeout_err: err %b busy %b state %0d, required 1 1 8", err, busy, state_o);
    end
    abort = 1; @(negedge clk); abort = 0;
    checks++;
    if ({err, busy, state_o} !== {1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL timeout_abort: err %b busy %b state %0d, required 1 0 0", err, busy, state_o);
    end
    rst = 1; #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_rst: err %b, required 0", err); end
    @(negedge clk); rst = 0;
`else
    drive_pass(0, -1, -1, 0, 1, 600, nd, rc, ex);
    checks++;
    if ({ex, state_o, en_rotate, err} !== {1'b1, 4'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL unbounded_wait: expired %b state %0d en_rotate %b err %b, required 1 4 1 0",
                         ex, state_o, en_rotate, err);
    end
    abort = 1; @(negedge clk); abort = 0;
    checks++;
    if ({busy, state_o} !== 5'd0) begin
      errors++; $display("FAIL unbounded_abort: busy %b state %0d, required 0 0", busy, state_o);
    end
`endif
    sb_drain(nbad, fe, fo);
    checks++;
    if (nbad != 0) begin
      errors++; $display("FAIL withheld_events: %0d mismatches, first got kind %0d idx %0d, required kind %0d idx %0d",
                         nbad, fo.kind, fo.idx, fe.kind, fe.idx);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass("full_pass", 0, -1);
    test_full_pass("held_colpar", 1, -1);
    test_full_pass("restart_ignored", 0, 10);
    test_abort();
    test_rst_mid_pass();
    test_withheld_lane();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
